segment_scan_driver: RTL and testbench
======================================

SEGMENT_SCAN_DRIVER -- requirements
Module: segment_scan_driver

Interface
REQ-001 SHALL have parameter CLK_DIV, default 1000, giving clock cycles per digit slot (legal range 2..65535).
REQ-002 SHALL have parameter NUM_DIGITS, default 6, giving digit count (fixed 6 in this revision).
REQ-003 SHALL have port clk  input  1  single system clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset; one clock, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  upstream code word valid.
REQ-006 SHALL have port in_ready  output  1  block accepts a code word this cycle.
REQ-007 SHALL have port in_segment  input  16  16-segment code from the character encoder.
REQ-008 SHALL have port in_found  input  1  encoder found flag for in_segment.
REQ-009 SHALL have port seg_out  output  16  active-high segment drive for the selected digit.
REQ-010 SHALL have port dig_sel  output  6  one-hot active-high digit enable; bit 0 = leftmost digit.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse when a new frame goes live.

Function
REQ-012 SHALL transfer a word only on a rising clk edge with in_valid=1 and in_ready=1.
REQ-013 SHALL store each accepted word in a 6-entry shadow buffer at wr_ptr, then increment wr_ptr 0..5.
REQ-014 SHALL store 16'h0000 (blank) instead of in_segment when in_found=0.
REQ-015 SHALL implement write FSM states FILL (in_ready=1) and PENDING (in_ready=0).
REQ-016 SHALL move FILL->PENDING on acceptance at wr_ptr=5, wr_ptr wrapping to 0.
REQ-017 SHALL leave the upstream words unchanged while in_valid=1 and in_ready=0 (no acceptance, no drop).
REQ-018 SHALL run a prescaler 0..CLK_DIV-1, asserting tick for the cycle where count=CLK_DIV-1, then wrapping to 0.
REQ-019 SHALL advance scan index idx on each tick, 0..5, wrapping 5->0.
REQ-020 SHALL register seg_out=display_buf[idx] and dig_sel=one-hot(idx), updating the cycle after the tick.
REQ-021 SHALL force dig_sel=6'b000000 for exactly the first clk cycle of each digit slot (anti-ghost blanking); seg_out is already valid in that cycle.
REQ-022 SHALL commit shadow->display buffer only on the tick where idx wraps 5->0 while in PENDING (no frame tearing).
REQ-023 SHALL, on commit, return the FSM to FILL and pulse frame_done high for that single cycle.
REQ-024 SHALL drive seg_out with the new frame digit 0 in the cycle after commit.
REQ-025 SHALL, when a word is accepted and a commit occur in the same cycle, be impossible by construction: in_ready=0 in PENDING.
REQ-026 SHALL keep scanning the old display buffer unchanged while FILL or PENDING is in progress.
REQ-027 SHALL never drive more than one dig_sel bit high.

Reset
REQ-028 SHALL, while rst=1, hold outputs: in_ready=1, seg_out=16'h0000, dig_sel=6'b000000, frame_done=0.
REQ-029 SHALL, while rst=1, hold internals: FSM=FILL, wr_ptr=0, idx=0, prescaler=0, shadow and display buffers all 16'h0000.
REQ-030 SHALL, on rst asserted mid-fill or in PENDING, discard partial/pending frame; on release, refill starts at wr_ptr=0.
REQ-031 SHALL present dig_sel=6'b000001 from the first tick after rst release.

Verification (CLK_DIV=4)
REQ-032 SHALL cover: reset release, no input -> dig_sel cycles 000001..100000 with one blank cycle per slot, seg_out=0000, frame_done never high.
REQ-033 SHALL cover: six accepted words "A".."F" codes (A=16'hF3C0) with found=1 -> frame_done single pulse at 5->0 wrap; next cycle seg_out=16'hF3C0 with digit 0 selected.
REQ-034 SHALL cover: third word with in_found=0, segment=16'hFFFF -> digit 2 shows 16'h0000.
REQ-035 SHALL cover: seventh word held valid during PENDING -> in_ready=0 until commit; word accepted after commit into wr_ptr=0, nothing lost.
REQ-036 SHALL cover: rst pulse after 4 words -> old display stays 0000, next fill needs six fresh words before frame_done.
REQ-037 SHALL cover: in_valid toggled 1/0 per cycle -> exactly one store per handshake; count of stores equals count of valid&&ready edges.

Source files
------------

// File: rtl/segment_scan_driver.sv
// Six-digit 16-segment multiplexed display driver. A shadow buffer is filled over a
// valid/ready handshake and swapped into the scanned display buffer only at a frame boundary.
//
// state   | meaning
// --------+---------------------------------------------------------------
// FILL    | accepting code words into the shadow buffer at wr_ptr
// PENDING | shadow frame complete, waiting for the scan to wrap 5->0 to commit
module segment_scan_driver #(
   parameter int CLK_DIV    = 1000,
   parameter int NUM_DIGITS = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_segment,
   input  logic        in_found,
   output logic [15:0] seg_out,
   output logic [5:0]  dig_sel,
   output logic        frame_done
);

   localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
   localparam logic [15:0] DIV_PRE  = 16'(CLK_DIV - 2);
   localparam logic [2:0]  LAST_DIG = 3'(NUM_DIGITS - 1);

   typedef enum logic {
      FILL    = 1'b0,
      PENDING = 1'b1
   } wr_state_t;

   wr_state_t   state_q, state_d;
   logic [2:0]  wr_ptr_q, wr_ptr_d;
   logic [2:0]  idx_q, idx_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] shadow_q  [NUM_DIGITS];
   logic [15:0] display_q [NUM_DIGITS];
   logic [15:0] seg_q;
   logic [5:0]  dig_q;
   logic        frame_q;
   logic        run_q;
   logic        blank_q;

   logic        tick;
   logic        wrap;
   logic        accept;
   logic        commit;
   logic [15:0] wr_data;

   always_comb begin
      tick     = (cnt_q == DIV_LAST);
      wrap     = run_q && (idx_q == LAST_DIG);
      accept   = in_valid && (state_q == FILL);
      commit   = tick && wrap && (state_q == PENDING);
      wr_data  = in_found ? in_segment : 16'h0000;
      cnt_d    = tick ? 16'd0 : cnt_q + 16'd1;
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      idx_d    = idx_q;
      if (accept) begin
         if (wr_ptr_q == LAST_DIG) begin
            wr_ptr_d = 3'd0;
            state_d  = PENDING;
         end else begin
            wr_ptr_d = wr_ptr_q + 3'd1;
         end
      end
      if (commit) begin
         state_d = FILL;
      end
      // The first tick after reset shows digit 0 rather than advancing past it.
      if (tick && run_q) begin
         idx_d = wrap ? 3'd0 : idx_q + 3'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= FILL;
         wr_ptr_q <= 3'd0;
         idx_q    <= 3'd0;
         cnt_q    <= 16'd0;
         seg_q    <= 16'h0000;
         dig_q    <= 6'b000000;
         frame_q  <= 1'b0;
         run_q    <= 1'b0;
         blank_q  <= 1'b0;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            shadow_q[i]  <= 16'h0000;
            display_q[i] <= 16'h0000;
         end
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         blank_q  <= tick;
         // Look one cycle ahead so the registered pulse lines up with the commit tick.
         frame_q  <= (cnt_q == DIV_PRE) && wrap && (state_d == PENDING);
         if (accept) begin
            shadow_q[wr_ptr_q] <= wr_data;
         end
         if (commit) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
               display_q[i] <= shadow_q[i];
            end
         end
         if (tick) begin
            run_q <= 1'b1;
            seg_q <= commit ? shadow_q[0] : display_q[idx_d];
            dig_q <= 6'b000000;
         end else if (blank_q) begin
            dig_q <= 6'd1 << idx_q;
         end
      end
   end

   assign in_ready   = (state_q == FILL);
   assign seg_out    = seg_q;
   assign dig_sel    = dig_q;
   assign frame_done = frame_q;

endmodule

// File: tb/tb_segment_scan_driver.sv
// Directed bench for segment_scan_driver with CLK_DIV=4: scan timing, frame commit,
// blanking of not-found codes, back-pressure in PENDING, reset mid-fill and toggled valid.
module tb_segment_scan_driver;

   localparam int CLK_DIV = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_found = 1'b0;
   logic [15:0] in_segment = 16'h0000;
   logic        in_ready;
   logic [15:0] seg_out;
   logic [5:0]  dig_sel;
   logic        frame_done;

   int checks = 0;
   int errors = 0;

   // Frames packed with digit 0 in the low 16 bits.
   localparam logic [95:0] F1  = {16'hC380, 16'hCF80, 16'hFC22, 16'hCF00, 16'hFCA8, 16'hF3C0};
   localparam logic [95:0] F2  = {16'h6666, 16'h5555, 16'h4444, 16'hFFFF, 16'h2222, 16'h1111};
   localparam logic [95:0] F2X = {16'h6666, 16'h5555, 16'h4444, 16'h0000, 16'h2222, 16'h1111};
   localparam logic [95:0] F3  = {16'hCCCC, 16'hBBBB, 16'hAAAA, 16'h9999, 16'h8888, 16'h7777};
   localparam logic [95:0] F4  = {16'h0F06, 16'h0F05, 16'h0F04, 16'h0F03, 16'h0F02, 16'h0F01};
   localparam logic [95:0] F5  = {16'h3006, 16'h3005, 16'h3004, 16'h3003, 16'h3002, 16'h3001};

   segment_scan_driver #(.CLK_DIV(CLK_DIV), .NUM_DIGITS(6)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_segment (in_segment),
      .in_found   (in_found),
      .seg_out    (seg_out),
      .dig_sel    (dig_sel),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   // Sends words first..last of a frame; called and returns on a negedge.
   task automatic send_range(input logic [95:0] segs, input logic [5:0] found,
                             input int first, input int last);
      bit ok;
      for (int w = first; w <= last; w++) begin
         in_valid   = 1'b1;
         in_segment = segs[w*16 +: 16];
         in_found   = found[w];
         ok = 1'b0;
         for (int i = 0; i < 200 && !ok; i++) begin
            ok = in_ready;
            @(negedge clk);
         end
         in_valid = 1'b0;
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL send_word%0d: in_ready never 1, required 1", w);
         end
      end
   endtask

   task automatic wait_commit(input logic [15:0] exp0);
      int i;
      for (i = 0; i < 200 && frame_done !== 1'b1; i++) @(negedge clk);
      checks++;
      if (frame_done !== 1'b1) begin
         errors++;
         $display("FAIL frame_done_timeout: frame_done=%b required 1", frame_done);
         return;
      end
      @(negedge clk);
      checks++;
      if ({frame_done, seg_out, dig_sel} !== {1'b0, exp0, 6'b000000}) begin
         errors++;
         $display("FAIL post_commit: fd=%b seg=%h dig=%b required fd=0 seg=%h dig=000000",
                  frame_done, seg_out, dig_sel, exp0);
      end
      @(negedge clk);
      checks++;
      if ({seg_out, dig_sel} !== {exp0, 6'b000001}) begin
         errors++;
         $display("FAIL digit0_live: seg=%h dig=%b required seg=%h dig=000001",
                  seg_out, dig_sel, exp0);
      end
   endtask

   task automatic check_display(input logic [95:0] exp);
      for (int i = 0; i < 100 && dig_sel !== 6'b000001; i++) @(negedge clk);
      checks++;
      if (dig_sel !== 6'b000001) begin
         errors++;
         $display("FAIL display_sync: dig=%b required 000001", dig_sel);
         return;
      end
      for (int d = 0; d < 6; d++) begin
         checks++;
         if ({seg_out, dig_sel} !== {exp[d*16 +: 16], 6'b000001 << d}) begin
            errors++;
            $display("FAIL display_digit%0d: seg=%h dig=%b required seg=%h dig=%b",
                     d, seg_out, dig_sel, exp[d*16 +: 16], 6'b000001 << d);
         end
         repeat (4) @(negedge clk);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if ({in_ready, frame_done, dig_sel, seg_out} !== {1'b1, 1'b0, 6'b000000, 16'h0000}) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b fd=%b dig=%b seg=%h required rdy=1 fd=0 dig=000000 seg=0000",
                     in_ready, frame_done, dig_sel, seg_out);
         end
         @(negedge clk);
      end
      rst = 1'b0;
   endtask

   task automatic test_idle_scan();
      logic [5:0] exp_dig;
      for (int c = 0; c < 56; c++) begin
         if (c < 4 || (c - 4) % 4 == 0) exp_dig = 6'b000000;
         else exp_dig = 6'b000001 << (((c - 4) / 4) % 6);
         checks++;
         if ({frame_done, seg_out, dig_sel} !== {1'b0, 16'h0000, exp_dig}) begin
            errors++;
            $display("FAIL idle_scan c=%0d: fd=%b seg=%h dig=%b required fd=0 seg=0000 dig=%b",
                     c, frame_done, seg_out, dig_sel, exp_dig);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_frame();
      send_range(F1, 6'b111111, 0, 5);
      wait_commit(16'hF3C0);
      check_display(F1);
   endtask

   task automatic test_not_found();
      send_range(F2, 6'b111011, 0, 5);
   endtask

   task automatic test_hold_pending();
      int fd_at, ready_at;
      fd_at = -1;
      ready_at = -1;
      in_valid   = 1'b1;
      in_segment = F3[15:0];
      in_found   = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if (frame_done === 1'b1 && fd_at < 0) fd_at = i;
         if (in_ready === 1'b1) begin
            ready_at = i;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (fd_at < 0 || ready_at != fd_at + 1) begin
         errors++;
         $display("FAIL hold_pending: ready at cycle %0d, frame_done at %0d, required ready one cycle after frame_done",
                  ready_at, fd_at);
      end
      check_display(F2X);
      send_range(F3, 6'b111111, 1, 5);
      wait_commit(16'h7777);
      check_display(F3);
   endtask

   task automatic test_reset_mid_fill();
      bit fd_seen;
      send_range(F4, 6'b111111, 0, 3);
      test_reset();
      check_display(96'h0);
      send_range(F4, 6'b111111, 0, 4);
      fd_seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (frame_done === 1'b1) fd_seen = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (fd_seen) begin
         errors++;
         $display("FAIL early_frame_done: frame_done seen after 5 fresh words, required none");
      end
      send_range(F4, 6'b111111, 5, 5);
      wait_commit(16'h0F01);
      check_display(F4);
   endtask

   task automatic test_back_to_back();
      int hs;
      hs = 0;
      for (int i = 0; i < 12; i++) begin
         in_valid   = (i % 2 == 0);
         in_found   = 1'b1;
         in_segment = in_valid ? F5[(i/2)*16 +: 16] : 16'hDEAD;
         if (in_valid && in_ready) hs++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      checks++;
      if (hs != 6) begin
         errors++;
         $display("FAIL toggle_handshakes: %0d handshakes, required 6", hs);
      end
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL toggle_pending: in_ready=%b required 0", in_ready);
      end
      wait_commit(16'h3001);
      check_display(F5);
   endtask

   initial begin
      test_reset();
      test_idle_scan();
      test_frame();
      test_not_found();
      test_hold_pending();
      test_reset_mid_fill();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
